// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO-to-serial converter.
// FIFO_SERIALIZER_PARITY_EN adds the PARITY state to the FSM encoding.
package fifo_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      POP    = 3'd1,
      LOAD   = 3'd2,
      SHIFT  = 3'd3
`ifdef FIFO_SERIALIZER_PARITY_EN
      , PARITY = 3'd4
`endif
   } ser_state_e;

endpackage

// File: rtl/fifo_ser_shreg.sv
// Parallel-load shift register with saturating bit counter.
// MSB_FIRST selects which end of the word is presented on bit_out.
module fifo_ser_shreg
   import fifo_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load,
   input  logic                         shift,
   input  logic [WIDTH-1:0]             d,
   output logic                         bit_out,
   output logic [$clog2(WIDTH+1)-1:0]   cnt,
   output logic                         last
);

   localparam int CW = $clog2(WIDTH+1);

   logic [WIDTH-1:0] sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= d;
         cnt <= '0;
      end else if (shift) begin
         if (MSB_FIRST) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
         end else begin
            sr <= {1'b0, sr[WIDTH-1:1]};
         end
         // Counter saturates on the last bit; the FSM leaves SHIFT there.
         if (!last) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign bit_out = MSB_FIRST ? sr[WIDTH-1] : sr[0];
   assign last    = (cnt == CW'(WIDTH-1));

endmodule

// File: rtl/fifo_serializer.sv
// Pops words from an upstream FIFO and streams them out one bit at a time
// with valid/ready. Define FIFO_SERIALIZER_PARITY_EN to append an even-parity bit.
module fifo_serializer
   import fifo_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             empty,
   input  logic [WIDTH-1:0] in_data,
   output logic             pop,
   input  logic             ser_ready,
   output logic             ser_valid,
   output logic             ser_out,
   output logic             ser_first,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH+1);

   // Handshake: a bit transfers on a rising edge where ser_valid and
   // ser_ready are both high; while ser_ready is low ser_out is held.

   ser_state_e    state;
   logic          load;
   logic          shift;
   logic          shreg_bit;
   logic          last;
   logic          cur_bit;
   logic [CW-1:0] cnt;

   assign load  = (state == LOAD);
   assign shift = (state == SHIFT) && ser_ready;

   fifo_ser_shreg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .shift   (shift),
      .d       (in_data),
      .bit_out (shreg_bit),
      .cnt     (cnt),
      .last    (last)
   );

`ifdef FIFO_SERIALIZER_PARITY_EN
   logic par_q;

   // Parity is taken from the word as loaded, before shifting destroys it.
   always_ff @(posedge clk) begin
      if (rst) begin
         par_q <= 1'b0;
      end else if (load) begin
         par_q <= ^in_data;
      end
   end

   assign cur_bit = (state == PARITY) ? par_q : shreg_bit;
`else
   assign cur_bit = shreg_bit;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pop       <= 1'b0;
         ser_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  state <= POP;
                  pop   <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            POP: begin
               state <= LOAD;
               pop   <= 1'b0;
            end
            LOAD: begin
               state     <= SHIFT;
               ser_valid <= 1'b1;
            end
            SHIFT: begin
               if (ser_ready && last) begin
`ifdef FIFO_SERIALIZER_PARITY_EN
                  state <= PARITY;
`else
                  ser_valid <= 1'b0;
                  if (!empty) begin
                     state <= POP;
                     pop   <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
`endif
               end
            end
`ifdef FIFO_SERIALIZER_PARITY_EN
            PARITY: begin
               if (ser_ready) begin
                  ser_valid <= 1'b0;
                  if (!empty) begin
                     state <= POP;
                     pop   <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
`endif
            default: begin
               state     <= IDLE;
               pop       <= 1'b0;
               ser_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign ser_out   = ser_valid & cur_bit;
   assign ser_first = ser_valid && (state == SHIFT) && (cnt == '0);

endmodule

// File: tb/tb_fifo_serializer.sv
// Directed bench for fifo_serializer (WIDTH=4, LSB first) with a queue-backed
// upstream FIFO model; parity checks follow FIFO_SERIALIZER_PARITY_EN.
module tb_fifo_serializer;

   logic       clk;
   logic       rst;
   logic       empty;
   logic [3:0] in_data;
   logic       pop;
   logic       ser_ready;
   logic       ser_valid;
   logic       ser_out;
   logic       ser_first;
   logic       busy;

   int checks;
   int failures;
   int pop_count;

   logic [3:0] fifo_q[$];

   typedef struct {
      logic [3:0] word;
      logic [3:0] seq;       // seq[i] is the i-th bit expected on ser_out
      logic       par;
      int         stall_at;
      int         stall_len;
   } vec_t;

   vec_t vecs[7];

   fifo_serializer #(
      .WIDTH     (4),
      .MSB_FIRST (1'b0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .empty     (empty),
      .in_data   (in_data),
      .pop       (pop),
      .ser_ready (ser_ready),
      .ser_valid (ser_valid),
      .ser_out   (ser_out),
      .ser_first (ser_first),
      .busy      (busy)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One clock: sample pop mid-cycle, then service the FIFO model after the edge.
   task automatic tick();
      logic p;
      @(negedge clk);
      p = pop;
      check("pop_while_empty", {31'd0, pop & empty}, 32'd0);
      @(posedge clk);
      #1;
      if (p === 1'b1) begin
         pop_count++;
         if (fifo_q.size() > 0) in_data = fifo_q.pop_front();
      end
      empty = (fifo_q.size() == 0);
   endtask

   task automatic push(input logic [3:0] w);
      fifo_q.push_back(w);
      empty = 1'b0;
   endtask

   // Called when POP should be visible; checks the whole frame.
   task automatic run_frame(input string tag, input logic [3:0] seq, input logic par,
                            input int stall_at, input int stall_len, input bit more);
      check({tag, "_pop"}, {31'd0, pop}, 32'd1);
      check({tag, "_pop_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_pop_valid"}, {31'd0, ser_valid}, 32'd0);
      tick();
      check({tag, "_load_pop"}, {31'd0, pop}, 32'd0);
      check({tag, "_load_valid"}, {31'd0, ser_valid}, 32'd0);
      check({tag, "_load_out"}, {31'd0, ser_out}, 32'd0);
      tick();
      for (int b = 0; b < 4; b++) begin
         if (b == stall_at) begin
            ser_ready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               check({tag, "_hold_valid"}, {31'd0, ser_valid}, 32'd1);
               check({tag, "_hold_out"}, {31'd0, ser_out}, {31'd0, seq[b]});
               check({tag, "_hold_first"}, {31'd0, ser_first}, {31'd0, b == 0});
               tick();
            end
            ser_ready = 1'b1;
         end
         check({tag, "_bit_valid"}, {31'd0, ser_valid}, 32'd1);
         check({tag, "_bit_out"}, {31'd0, ser_out}, {31'd0, seq[b]});
         check({tag, "_bit_first"}, {31'd0, ser_first}, {31'd0, b == 0});
         tick();
      end
`ifdef FIFO_SERIALIZER_PARITY_EN
      check({tag, "_par_valid"}, {31'd0, ser_valid}, 32'd1);
      check({tag, "_par_out"}, {31'd0, ser_out}, {31'd0, par});
      check({tag, "_par_first"}, {31'd0, ser_first}, 32'd0);
      tick();
`else
      if (par !== par) check({tag, "_unused"}, 32'd0, 32'd1);
`endif
      if (!more) begin
         check({tag, "_end_valid"}, {31'd0, ser_valid}, 32'd0);
         check({tag, "_end_out"}, {31'd0, ser_out}, 32'd0);
         check({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
         check({tag, "_end_pop"}, {31'd0, pop}, 32'd0);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      pop_count = 0;

      vecs[0] = '{word: 4'b1011, seq: 4'b1011, par: 1'b1, stall_at: -1, stall_len: 0};
      vecs[1] = '{word: 4'hA,    seq: 4'hA,    par: 1'b0, stall_at: 2,  stall_len: 3};
      vecs[2] = '{word: 4'h7,    seq: 4'h7,    par: 1'b1, stall_at: -1, stall_len: 0};
      vecs[3] = '{word: 4'h3,    seq: 4'h3,    par: 1'b0, stall_at: -1, stall_len: 0};
      vecs[4] = '{word: 4'h0,    seq: 4'h0,    par: 1'b0, stall_at: 3,  stall_len: 1};
      vecs[5] = '{word: 4'hF,    seq: 4'hF,    par: 1'b0, stall_at: -1, stall_len: 0};
      vecs[6] = '{word: 4'h5,    seq: 4'h5,    par: 1'b0, stall_at: 0,  stall_len: 2};

      // Reset held two cycles with a word waiting upstream.
      rst       = 1'b1;
      ser_ready = 1'b1;
      in_data   = 4'h0;
      empty     = 1'b1;
      push(4'h9);
      for (int r = 0; r < 2; r++) begin
         tick();
         check("rst_pop", {31'd0, pop}, 32'd0);
         check("rst_valid", {31'd0, ser_valid}, 32'd0);
         check("rst_busy", {31'd0, busy}, 32'd0);
         check("rst_out", {31'd0, ser_out}, 32'd0);
         check("rst_first", {31'd0, ser_first}, 32'd0);
      end
      rst = 1'b0;
      pop_count = 0;
      tick();
      run_frame("post_rst", 4'h9, 1'b0, -1, 0, 1'b0);
      check("post_rst_pops", pop_count, 32'd1);

      // Single-word frames from the table.
      foreach (vecs[i]) begin
         pop_count = 0;
         push(vecs[i].word);
         tick();
         run_frame($sformatf("vec%0d", i), vecs[i].seq, vecs[i].par,
                   vecs[i].stall_at, vecs[i].stall_len, 1'b0);
         check($sformatf("vec%0d_pops", i), pop_count, 32'd1);
      end

      // Back-to-back: POP follows the last bit directly.
      pop_count = 0;
      push(4'h3);
      push(4'hC);
      tick();
      run_frame("b2b0", 4'h3, 1'b0, -1, 0, 1'b1);
      run_frame("b2b1", 4'hC, 1'b0, -1, 0, 1'b0);
      check("b2b_pops", pop_count, 32'd2);

      // Mid-frame reset at bit 1.
      push(4'h6);
      tick();
      check("mrst_pop", {31'd0, pop}, 32'd1);
      tick();
      tick();
      check("mrst_bit0", {31'd0, ser_out}, 32'd0);
      check("mrst_first", {31'd0, ser_first}, 32'd1);
      tick();
      check("mrst_bit1", {31'd0, ser_out}, 32'd1);
      rst = 1'b1;
      tick();
      check("mrst_valid", {31'd0, ser_valid}, 32'd0);
      check("mrst_out", {31'd0, ser_out}, 32'd0);
      check("mrst_busy", {31'd0, busy}, 32'd0);
      check("mrst_popflag", {31'd0, pop}, 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("mrst_idle_busy", {31'd0, busy}, 32'd0);
         check("mrst_idle_valid", {31'd0, ser_valid}, 32'd0);
         check("mrst_idle_pop", {31'd0, pop}, 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
